// File: rtl/comb_bist_pkg.sv
// Shared definitions for the combinational BIST engine: FSM states,
// LFSR tap masks, MISR polynomials and the counter-width legality rule.
package comb_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } bist_state_e;

   // Maximal-length tap masks for a left-shifting Fibonacci LFSR; bit i set
   // means state bit i feeds the XOR that enters at bit 0.
   function automatic logic [15:0] lfsr_taps(input int n);
      logic [15:0] taps;
      case (n)
         3:       taps = 16'h0006;
         4:       taps = 16'h000C;
         5:       taps = 16'h0014;
         6:       taps = 16'h0030;
         7:       taps = 16'h0060;
         8:       taps = 16'h00B8;
         9:       taps = 16'h0110;
         10:      taps = 16'h0240;
         11:      taps = 16'h0500;
         12:      taps = 16'h0829;
         13:      taps = 16'h100D;
         14:      taps = 16'h2015;
         15:      taps = 16'h6000;
         16:      taps = 16'hD008;
         default: taps = 16'h0000;
      endcase
      return taps;
   endfunction

   function automatic logic [31:0] misr_poly(input int w);
      logic [31:0] poly;
      case (w)
         8:       poly = 32'h0000_001D;
         16:      poly = 32'h0000_1021;
         32:      poly = 32'h04C1_1DB7;
         default: poly = 32'h0000_0000;
      endcase
      return poly;
   endfunction

   // The counter must hold 2^n_in, the exhaustive pattern total.
   function automatic bit cnt_w_ok(input int cnt_w, input int n_in);
      return cnt_w >= n_in + 1;
   endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shifts left with polynomial feedback
// and XORs in the zero-extended response word each enabled cycle.
module bist_misr
   import comb_bist_pkg::*;
#(
   parameter int MISR_W = 16,
   parameter int N_OUT  = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [N_OUT-1:0]  data_i,
   output logic [MISR_W-1:0] sig_o,
   output logic [MISR_W-1:0] sig_next_o
);

   localparam logic [31:0]       POLY_ALL = misr_poly(MISR_W);
   localparam logic [MISR_W-1:0] POLY     = POLY_ALL[MISR_W-1:0];

   logic [MISR_W-1:0] sig_q;
   logic [MISR_W-1:0] dataExt;

   assign dataExt    = MISR_W'(data_i);
   assign sig_next_o = {sig_q[MISR_W-2:0], 1'b0}
                     ^ (sig_q[MISR_W-1] ? POLY : '0)
                     ^ dataExt;
   assign sig_o      = sig_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         sig_q <= '0;
      end else if (en_i) begin
         sig_q <= sig_next_o;
      end
   end

endmodule

// File: rtl/comb_bist_engine.sv
// BIST engine: drives a combinational CUT from an exhaustive counter or an
// LFSR, compacts responses in a MISR and compares against a golden value.
module comb_bist_engine
   import comb_bist_pkg::*;
#(
   parameter int N_IN   = 5,
   parameter int N_OUT  = 2,
   parameter int MISR_W = 16,
   parameter int CNT_W  = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [CNT_W-1:0]  pat_count,
   input  logic [MISR_W-1:0] golden,
   output logic [N_IN-1:0]   cut_in,
   input  logic [N_OUT-1:0]  cut_out,
   output logic              busy,
   output logic              done,
   output logic [MISR_W-1:0] signature,
   output logic              pass
);

   if (!cnt_w_ok(CNT_W, N_IN)) begin : g_bad_cnt_w
      $error("comb_bist_engine: CNT_W must be at least N_IN+1");
   end

   localparam logic [15:0]      TAPS_ALL    = lfsr_taps(N_IN);
   localparam logic [N_IN-1:0]  TAPS        = TAPS_ALL[N_IN-1:0];
   localparam logic [CNT_W-1:0] EXH_TOTAL   = CNT_W'(1) << N_IN;
   localparam logic [CNT_W-1:0] LFSR_PERIOD = EXH_TOTAL - 1'b1;

   bist_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic              mode_q, mode_d;
   logic [N_IN-1:0]   cut_q, cut_d;
   logic              pass_q, pass_d;
   logic              misrClr, misrEn;
   logic [MISR_W-1:0] sigNext;
   logic [N_IN-1:0]   lfsrNext;

   assign lfsrNext = {cut_q[N_IN-2:0], ^(cut_q & TAPS)};

   // A start from IDLE or DONE reseeds everything; in RUN each edge absorbs
   // the current response and the edge that absorbs the last one latches pass.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      total_d = total_q;
      mode_d  = mode_q;
      cut_d   = cut_q;
      pass_d  = pass_q;
      misrClr = 1'b0;
      misrEn  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               mode_d  = mode;
               cut_d   = mode ? N_IN'(1) : '0;
               cnt_d   = '0;
               pass_d  = 1'b0;
               misrClr = 1'b1;
               if (!mode) begin
                  total_d = EXH_TOTAL;
               end else if (pat_count == '0) begin
                  total_d = LFSR_PERIOD;
               end else begin
                  total_d = pat_count;
               end
            end
         end
         ST_RUN: begin
            misrEn = 1'b1;
            cut_d  = mode_q ? lfsrNext : cut_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == total_q - 1'b1) begin
               state_d = ST_DONE;
               pass_d  = (sigNext == golden);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         total_q <= '0;
         mode_q  <= 1'b0;
         cut_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
         mode_q  <= mode_d;
         cut_q   <= cut_d;
         pass_q  <= pass_d;
      end
   end

   bist_misr #(
      .MISR_W (MISR_W),
      .N_OUT  (N_OUT)
   ) u_misr (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_i      (misrClr),
      .en_i       (misrEn),
      .data_i     (cut_out),
      .sig_o      (signature),
      .sig_next_o (sigNext)
   );

   assign cut_in = cut_q;
   assign busy   = (state_q == ST_RUN);
   assign done   = (state_q == ST_DONE);
   assign pass   = pass_q;

endmodule

// File: tb/tb_comb_bist_engine.sv
// Randomised self-checking bench for comb_bist_engine with the CUT modelled
// as a loopback of the two low cut_in bits.
module tb_comb_bist_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic [16:0] pat_count;
   logic [15:0] golden;
   logic [4:0]  cut_in;
   logic [1:0]  cut_out;
   logic        busy;
   logic        done;
   logic [15:0] signature;
   logic        pass;

   int nChecks = 0;
   int nPass   = 0;

   logic [4:0] lfsrSeq [0:30];
   logic [4:0] obs [0:511];

   bit          checkEn = 1'b0;
   bit          mRun    = 1'b0;
   bit          mDone   = 1'b0;
   bit          mPass   = 1'b0;
   bit          mMode   = 1'b0;
   int          mTotal  = 0;
   int          mK      = 0;
   logic [15:0] mSig    = '0;

   always #5 clk = ~clk;

   assign cut_out = cut_in[1:0];

   comb_bist_engine #(
      .N_IN   (5),
      .N_OUT  (2),
      .MISR_W (16),
      .CNT_W  (17)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .pat_count (pat_count),
      .golden    (golden),
      .cut_in    (cut_in),
      .cut_out   (cut_out),
      .busy      (busy),
      .done      (done),
      .signature (signature),
      .pass      (pass)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Signature update viewed as polynomial arithmetic: sig*x mod P plus response.
   function automatic logic [15:0] misrStep(input logic [15:0] sig, input logic [1:0] resp);
      logic [15:0] t;
      t = {sig[14:0], 1'b0};
      if (sig[15]) t = t ^ 16'h1021;
      return t ^ {14'b0, resp};
   endfunction

   function automatic logic [4:0] patternAt(input bit m, input int k);
      logic [4:0] p;
      if (m) p = lfsrSeq[k % 31];
      else   p = 5'(k % 32);
      return p;
   endfunction

   function automatic int calcTotal(input bit m, input logic [16:0] pc);
      if (!m) return 32;
      if (pc == 0) return 31;
      return int'(pc);
   endfunction

   function automatic logic [15:0] expectedSig(input bit m, input int total);
      logic [15:0] s;
      logic [4:0]  p;
      s = '0;
      for (int k = 0; k < total; k++) begin
         p = patternAt(m, k);
         s = misrStep(s, p[1:0]);
      end
      return s;
   endfunction

   // Reference model: tracks which pattern index is on the CUT and the
   // signature accumulated so far, from the inputs alone.
   always @(posedge clk) begin
      if (rst) begin
         mRun    <= 1'b0;
         mDone   <= 1'b0;
         mPass   <= 1'b0;
         mSig    <= '0;
         mK      <= 0;
         checkEn <= 1'b1;
      end else if (!mRun && start) begin
         mRun   <= 1'b1;
         mDone  <= 1'b0;
         mPass  <= 1'b0;
         mMode  <= mode;
         mTotal <= calcTotal(mode, pat_count);
         mK     <= 0;
         mSig   <= '0;
      end else if (mRun) begin
         mSig <= misrStep(mSig, patternAt(mMode, mK) & 5'b00011);
         mK   <= mK + 1;
         if (mK == mTotal - 1) begin
            mRun  <= 1'b0;
            mDone <= 1'b1;
            mPass <= (misrStep(mSig, patternAt(mMode, mK) & 5'b00011) == golden);
         end
      end
   end

   // Per-cycle comparison of every meaningful output against the model.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("busy", 32'(busy), 32'(mRun));
         checkOutput("done", 32'(done), 32'(mDone));
         checkOutput("signature", 32'(signature), 32'(mSig));
         if (mRun) checkOutput("cut_in", 32'(cut_in), 32'(patternAt(mMode, mK)));
         else if (!mDone) checkOutput("cut_in_idle", 32'(cut_in), 32'h0);
         if (!mRun) checkOutput("pass", 32'(pass), 32'(mPass));
      end
   end

   // Issues one start and follows the run; disturb 1 pulses start at RUN
   // cycles 3 and 10, disturb 2 asserts rst at RUN cycle 7.
   task automatic applyStimulus(input bit m, input logic [16:0] pc, input logic [15:0] g,
                                input int disturb, output int busyCycles, output int doneCycle);
      int cyc;
      start     = 1'b1;
      mode      = m;
      pat_count = pc;
      golden    = g;
      @(negedge clk);
      start     = 1'b0;
      mode      = 1'($urandom_range(1, 0));
      pat_count = 17'($urandom_range(200, 0));
      busyCycles = 0;
      doneCycle  = -1;
      cyc        = 0;
      while (cyc < 300) begin
         if (busy) begin
            if (busyCycles < 512) obs[busyCycles] = cut_in;
            busyCycles++;
         end
         if (done) begin
            doneCycle = cyc;
            break;
         end
         if (disturb == 2 && cyc == 8) begin
            rst = 1'b0;
            break;
         end
         start = (disturb == 1 && (cyc == 3 || cyc == 10));
         if (disturb == 2 && cyc == 7) rst = 1'b1;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (disturb != 2 && doneCycle < 0) checkOutput("done_timeout", 32'h0, 32'h1);
   endtask

   initial begin
      int          bc, dc, cnt;
      logic [15:0] gold, g, e;
      bit          seen [0:31];
      bit          m;
      logic [16:0] pc;
      logic [4:0]  st;
      int          rptBad;

      rst       = 1'b1;
      start     = 1'b0;
      mode      = 1'b0;
      pat_count = '0;
      golden    = '0;

      st = 5'd1;
      for (int i = 0; i < 31; i++) begin
         lfsrSeq[i] = st;
         st = {st[3:0], st[4] ^ st[2]};
      end

      checkOutput("model_lfsr0", 32'(lfsrSeq[0]), 32'd1);
      checkOutput("model_lfsr1", 32'(lfsrSeq[1]), 32'd2);
      checkOutput("model_lfsr3", 32'(lfsrSeq[3]), 32'd9);
      checkOutput("model_lfsr4", 32'(lfsrSeq[4]), 32'd18);
      checkOutput("model_lfsr5", 32'(lfsrSeq[5]), 32'd5);
      checkOutput("model_misr_fold", 32'(expectedSig(1'b0, 4)), 32'h3);
      checkOutput("model_misr_poly", 32'(misrStep(16'h8000, 2'b00)), 32'h1021);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] exhaustive run, matching golden");
      gold = expectedSig(1'b0, 32);
      applyStimulus(1'b0, 17'd0, gold, 0, bc, dc);
      checkOutput("exh_busy_len", 32'(bc), 32'd32);
      checkOutput("exh_done_cycle", 32'(dc), 32'd32);
      checkOutput("exh_pass", 32'(pass), 32'h1);
      checkOutput("exh_sig", 32'(signature), 32'(gold));
      for (int i = 0; i < 32; i++)
         if (obs[i] !== 5'(i)) checkOutput("exh_step", 32'(obs[i]), 32'(i));

      $display("[TB] exhaustive run, golden off by one bit");
      g = gold ^ (16'h1 << $urandom_range(15, 0));
      applyStimulus(1'b0, 17'd0, g, 0, bc, dc);
      checkOutput("bad_gold_pass", 32'(pass), 32'h0);
      checkOutput("bad_gold_done", 32'(done), 32'h1);
      checkOutput("bad_gold_sig", 32'(signature), 32'(gold));

      $display("[TB] LFSR run, pat_count 0");
      applyStimulus(1'b1, 17'd0, 16'($urandom), 0, bc, dc);
      checkOutput("lfsr_busy_len", 32'(bc), 32'd31);
      for (int i = 0; i < 32; i++) seen[i] = 1'b0;
      cnt = 0;
      for (int i = 0; i < 31; i++)
         if (obs[i] != 5'd0 && !seen[obs[i]]) begin
            seen[obs[i]] = 1'b1;
            cnt++;
         end
      checkOutput("lfsr_distinct", 32'(cnt), 32'd31);

      $display("[TB] LFSR run, pat_count 40");
      applyStimulus(1'b1, 17'd40, 16'($urandom), 0, bc, dc);
      checkOutput("lfsr40_busy_len", 32'(bc), 32'd40);
      rptBad = 0;
      for (int j = 0; j < 9; j++)
         if (obs[31 + j] !== obs[j]) rptBad++;
      checkOutput("lfsr40_repeat", 32'(rptBad), 32'd0);

      $display("[TB] exhaustive run with stray start pulses");
      applyStimulus(1'b0, 17'd0, gold, 1, bc, dc);
      checkOutput("stray_busy_len", 32'(bc), 32'd32);
      checkOutput("stray_sig", 32'(signature), 32'(gold));
      checkOutput("stray_pass", 32'(pass), 32'h1);

      $display("[TB] reset during run");
      applyStimulus(1'b0, 17'd0, gold, 2, bc, dc);
      checkOutput("abort_busy", 32'(busy), 32'h0);
      checkOutput("abort_done", 32'(done), 32'h0);
      checkOutput("abort_sig", 32'(signature), 32'h0);
      checkOutput("abort_cut", 32'(cut_in), 32'h0);
      checkOutput("abort_pass", 32'(pass), 32'h0);
      applyStimulus(1'b0, 17'd0, gold, 0, bc, dc);
      checkOutput("rerun_sig", 32'(signature), 32'(gold));
      checkOutput("rerun_pass", 32'(pass), 32'h1);

      $display("[TB] random runs");
      for (int r = 0; r < 8; r++) begin
         m  = 1'($urandom_range(1, 0));
         pc = 17'($urandom_range(70, 0));
         e  = expectedSig(m, calcTotal(m, pc));
         g  = ($urandom_range(1, 0) != 0) ? e : 16'($urandom);
         applyStimulus(m, pc, g, ($urandom_range(1, 0) != 0) ? 1 : 0, bc, dc);
         checkOutput("rand_busy_len", 32'(bc), 32'(calcTotal(m, pc)));
         checkOutput("rand_sig", 32'(signature), 32'(e));
         checkOutput("rand_pass", 32'(pass), 32'(g == e));
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
